rca_pipe: RTL and testbench

Parametrised, pipelined ripple-carry adder/subtractor, the successor to the team's 8-bit combinational ripple-carry adder. The WIDTH-bit carry chain is split into STAGES equal chunks, with a register boundary after each chunk. Operands skew into the pipe and sum bits de-skew out, so one operation is accepted per cycle. A valid/ready handshake on both sides supports back-pressure. It sits between operand-producing datapath blocks and result consumers that may stall.

---
 rtl/rca_pipe.sv | 130 +++++++++++++
 tb/tb_rca_pipe.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/rca_pipe.sv
// rca_pipe: pipelined ripple-carry adder/subtractor with valid/ready handshake.
// The WIDTH-bit carry chain is cut into STAGES chunks of C = WIDTH/STAGES bits,
// one register boundary per chunk, so one operation is accepted per cycle.
// Ports:
//   clk, rst             clock, asynchronous active-high reset
//   in_valid / in_ready  operand handshake (in_ready = ~out_valid | out_ready)
//   a, b, cin, sub       operands, carry/borrow-in, 0 = add / 1 = subtract
//   out_valid/out_ready  result handshake
//   s, cout, ovf         sum/difference, chain carry-out, signed overflow
module rca_pipe #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);
    localparam int C = WIDTH / STAGES;

    logic             adv;
    logic [WIDTH-1:0] b_x;
    logic             c_x;
    logic             ovf_d, ovf_q;

    if (WIDTH < 2 || STAGES < 1 || WIDTH % STAGES != 0) begin : g_bad_params
        $error("rca_pipe: WIDTH must be >= 2 and a multiple of STAGES");
    end

    // Subtraction reuses the adder chain as a + ~b + ~cin.
    always_comb begin
        b_x = sub ? ~b : b;
        c_x = sub ? ~cin : cin;
    end

    for (genvar g = 0; g < STAGES; g++) begin : stg
        localparam int SW = (g + 1) * C;
        localparam int RW = WIDTH - SW;
        logic [C-1:0]  xa, xb;
        logic          xc;
        logic [C:0]    sum;
        logic [SW-1:0] s_d, s_q;
        logic          c_d, c_q, v_d, v_q;
        if (g == 0) begin : src
            always_comb begin
                xa  = a[C-1:0];
                xb  = b_x[C-1:0];
                xc  = c_x;
                sum = {1'b0, xa} + {1'b0, xb} + {{C{1'b0}}, xc};
                s_d = sum[C-1:0];
                c_d = sum[C];
                v_d = in_valid;
            end
        end else begin : src
            // Each chunk's sum lands on top of the lower sums from upstream.
            always_comb begin
                xa  = stg[g-1].rem.a_q[C-1:0];
                xb  = stg[g-1].rem.b_q[C-1:0];
                xc  = stg[g-1].c_q;
                sum = {1'b0, xa} + {1'b0, xb} + {{C{1'b0}}, xc};
                s_d = {sum[C-1:0], stg[g-1].s_q};
                c_d = sum[C];
                v_d = stg[g-1].v_q;
            end
        end
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                s_q <= '0;
                c_q <= 1'b0;
                v_q <= 1'b0;
            end else if (adv) begin
                s_q <= s_d;
                c_q <= c_d;
                v_q <= v_d;
            end
        end
        // Operand bits of the chunks still to be added travel alongside.
        if (RW > 0) begin : rem
            logic [RW-1:0] a_d, a_q, b_d, b_q;
            if (g == 0) begin : src
                always_comb begin
                    a_d = a[WIDTH-1:C];
                    b_d = b_x[WIDTH-1:C];
                end
            end else begin : src
                always_comb begin
                    a_d = stg[g-1].rem.a_q[RW+C-1:C];
                    b_d = stg[g-1].rem.b_q[RW+C-1:C];
                end
            end
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q <= '0;
                    b_q <= '0;
                end else if (adv) begin
                    a_q <= a_d;
                    b_q <= b_d;
                end
            end
        end
    end

    always_comb begin
        out_valid = stg[STAGES-1].v_q;
        adv       = ~out_valid | out_ready;
        in_ready  = adv;
        s         = stg[STAGES-1].s_q;
        cout      = stg[STAGES-1].c_q;
        ovf       = ovf_q;
        // Carry into the MSB is recovered from its sum bit and its two inputs.
        ovf_d     = stg[STAGES-1].sum[C] ^ stg[STAGES-1].sum[C-1]
                  ^ stg[STAGES-1].xa[C-1] ^ stg[STAGES-1].xb[C-1];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_q <= 1'b0;
        else if (adv)
            ovf_q <= ovf_d;
    end
endmodule

// File: tb/tb_rca_pipe.sv
// tb_rca_pipe: scoreboard bench for rca_pipe at 8/2, 16/4 and 8/1.
module tb_rca_pipe;
    typedef struct {
        logic [17:0] r;
        int          cyc;
        int          stl;
    } exp_t;

    typedef struct packed {
        logic [15:0] x;
        logic [15:0] y;
        logic        c;
        logic        sb;
    } op_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        out_ready;
    logic [15:0] a_in, b_in;
    logic        cin, sub;
    int          cyc = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic [9:0]  held;

    op_t dir [12] = '{
        '{16'h00FF, 16'h0001, 1'b0, 1'b0},
        '{16'h007F, 16'h0001, 1'b0, 1'b0},
        '{16'h0005, 16'h0007, 1'b0, 1'b1},
        '{16'h0080, 16'h0001, 1'b0, 1'b1},
        '{16'h0010, 16'h000F, 1'b1, 1'b1},
        '{16'hFFFF, 16'h0001, 1'b0, 1'b0},
        '{16'h000F, 16'h0001, 1'b0, 1'b0},
        '{16'h0FFF, 16'h0001, 1'b0, 1'b0},
        '{16'h7FFF, 16'h0001, 1'b0, 1'b0},
        '{16'h8000, 16'h0001, 1'b0, 1'b1},
        '{16'h0000, 16'h0000, 1'b1, 1'b1},
        '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0}
    };

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference: plain integer arithmetic on unsigned and signed views.
    function automatic logic [17:0] model(int w, logic [15:0] x, logic [15:0] y, logic ci, logic sb);
        longint m  = (longint'(1) << w) - 1;
        longint h  = longint'(1) << (w - 1);
        longint c  = longint'(ci);
        longint ux = longint'(x) & m;
        longint uy = longint'(y) & m;
        longint sx = (ux >= h) ? ux - 2 * h : ux;
        longint sy = (uy >= h) ? uy - 2 * h : uy;
        longint r, sr;
        logic   co;
        if (sb) begin
            r  = ux - uy - c;
            sr = sx - sy - c;
            co = ux >= uy + c;
        end else begin
            r  = ux + uy + c;
            sr = sx + sy + c;
            co = r > m;
        end
        return {(sr < -h) || (sr >= h), co, 16'(r & m)};
    endfunction

    task automatic chk(input string nm, input longint act, input longint exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    for (genvar i = 0; i < 3; i++) begin : u
        localparam int W  = (i == 1) ? 16 : 8;
        localparam int ST = (i == 0) ? 2 : (i == 1) ? 4 : 1;
        logic         rdy, ov, co, of;
        logic [W-1:0] s;
        exp_t         q[$];
        exp_t         e;
        int           stl = 0;

        rca_pipe #(.WIDTH(W), .STAGES(ST)) dut (
            .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy),
            .a(a_in[W-1:0]), .b(b_in[W-1:0]), .cin(cin), .sub(sub),
            .out_valid(ov), .out_ready(out_ready), .s(s), .cout(co), .ovf(of)
        );

        // Capture: an accepted operation predicts its result; stalled cycles
        // are counted so the monitor knows how long the pipe was frozen.
        always @(negedge clk) begin
            #1;
            if (rst) begin
                q.delete();
            end else begin
                if (!rdy) stl++;
                if (in_valid && rdy) q.push_back('{model(W, a_in, b_in, cin, sub), cyc, stl});
            end
        end

        // Monitor: every result leaving the DUT is matched in order.
        always @(negedge clk) begin
            #2;
            if (!rst && ov && out_ready) begin
                if (q.size() == 0) begin
                    chk($sformatf("w%0d_s%0d spurious output", W, ST), 1, 0);
                end else begin
                    e = q.pop_front();
                    chk($sformatf("w%0d_s%0d result {ovf,cout,s}", W, ST), {of, co, 16'(s)}, e.r);
                    chk($sformatf("w%0d_s%0d latency", W, ST), cyc - e.cyc, ST + stl - e.stl);
                end
            end
        end
    end

    task automatic drive(input bit v, input logic [15:0] x, input logic [15:0] y,
                         input logic c, input logic sb, input bit r);
        @(negedge clk);
        in_valid  = v;
        a_in      = x;
        b_in      = y;
        cin       = c;
        sub       = sb;
        out_ready = r;
    endtask

    task automatic rnd(input bit v, input bit r);
        drive(v, 16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), r);
    endtask

    task automatic idle(input int n);
        repeat (n) rnd(0, 1);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        a_in = '0; b_in = '0; cin = 1'b0; sub = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("reset out_valid", u[0].ov, 0);
        chk("reset s", u[0].s, 0);
        chk("reset cout", u[0].co, 0);
        chk("reset ovf", u[0].of, 0);
        chk("reset w16 s", u[1].s, 0);
        chk("reset w8s1 out_valid", u[2].ov, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("in_ready after reset", u[0].rdy, 1);

        foreach (dir[k]) drive(1, dir[k].x, dir[k].y, dir[k].c, dir[k].sb, 1);
        idle(8);

        repeat (16) rnd(1, 1);
        idle(8);

        repeat (6) rnd(1, 1);
        rnd(1, 0);
        #1;
        chk("stall out_valid", u[0].ov, 1);
        chk("stall in_ready", u[0].rdy, 0);
        held = {u[0].of, u[0].co, u[0].s};
        repeat (2) begin
            rnd(1, 0);
            #1;
            chk("stall in_ready", u[0].rdy, 0);
            chk("stall output hold", {u[0].of, u[0].co, u[0].s}, held);
        end
        repeat (4) rnd(1, 1);
        idle(8);

        repeat (300) rnd($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
        idle(10);

        rnd(1, 0);
        rnd(1, 0);
        rnd(0, 0);
        #3 rst = 1'b1;
        #1;
        chk("mid reset out_valid", u[0].ov, 0);
        chk("mid reset s", u[0].s, 0);
        chk("mid reset cout", u[0].co, 0);
        chk("mid reset ovf", u[0].of, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) begin
            rnd(0, 1);
            #1;
            chk("post reset out_valid", u[0].ov, 0);
            chk("post reset w16 out_valid", u[1].ov, 0);
        end

        repeat (8) rnd(1, 1);
        idle(10);
        chk("w8_s2 drained", u[0].q.size(), 0);
        chk("w16_s4 drained", u[1].q.size(), 0);
        chk("w8_s1 drained", u[2].q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
